// File: rtl/gamepad_events_if.sv
// rtl/gamepad_events_if.sv - valid/ready event stream carrying {pressed, pad, button}
interface gamepad_events_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [6:0] ev_data;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/gamepad_events.sv
// rtl/gamepad_events.sv - frame diff of four pad words into a press/release event FIFO
module gamepad_events #(
  parameter int          FIFO_DEPTH  = 16,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter logic [15:0] BUTTON_MASK = 16'h0FFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   gp1,
  input  logic [15:0]                   gp2,
  input  logic [15:0]                   gp3,
  input  logic [15:0]                   gp4,
  input  logic                          gp_data_ready,
  gamepad_events_if.master              ev,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic [63:0]                   buttons,
  output logic                          overflow,
  output logic                          missed,
  input  logic                          clr_status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q;
  logic          rdy_q;
  logic [5:0]    idx_q;
  logic [63:0]   snap_q;
  logic [63:0]   prev_q;
  logic [63:0]   buttons_q;
  logic          overflow_q;
  logic          missed_q;

  logic [6:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic [63:0]   raw;
  logic [63:0]   cur;
  logic          new_frame;
  logic          scan_diff;
  logic          full;
  logic          pop;
  logic          do_push;

  assign raw       = {gp4, gp3, gp2, gp1};
  assign cur       = (ACTIVE_LOW ? ~raw : raw) & {4{BUTTON_MASK}};
  assign new_frame = gp_data_ready & ~rdy_q;
  assign scan_diff = (state_q == SCAN) && (snap_q[idx_q] != prev_q[idx_q]);
  // Fullness is judged before this cycle's pop, so a push into a full FIFO is always dropped.
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = (count_q != '0) & ev.ev_ready;
  assign do_push   = scan_diff & ~full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      idx_q      <= '0;
      snap_q     <= '0;
      prev_q     <= '0;
      buttons_q  <= '0;
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      rdy_q <= gp_data_ready;
      if (clr_status) begin
        overflow_q <= 1'b0;
        missed_q   <= 1'b0;
      end
      if (scan_diff && full) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (new_frame) begin
            snap_q  <= cur;
            idx_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (new_frame) missed_q <= 1'b1;
          idx_q <= idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            prev_q    <= snap_q;
            buttons_q <= snap_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {snap_q[idx_q], idx_q};
  end

  assign ev.ev_valid = (count_q != '0);
  assign ev.ev_data  = mem_q[rd_ptr_q];
  assign ev_count    = count_q;
  assign buttons     = buttons_q;
  assign overflow    = overflow_q;
  assign missed      = missed_q;

endmodule

// File: doc/gamepad_events.md
# gamepad_events

Converts the parallel button words produced by the gamepad read-out block into a stream of press/release events. On each new frame it snapshots all four 16-bit pad words and compares them bit-by-bit against the previous frame, one bit per clock. It pushes one event per changed, unmasked button into a first-word-fall-through FIFO that firmware or game logic drains through a valid/ready port. It sits directly downstream of the gamepad shift-register reader and upstream of the SoC/game logic.

## Interface

**Parameters**
- `FIFO_DEPTH`, default 16: event FIFO entries; power of two, minimum 2.
- `ACTIVE_LOW`, default 1: when 1, a raw bit value of 0 means pressed.
- `BUTTON_MASK`, default 16'h0FFF: per-button enable, applied identically to all four pads. Masked bits never generate events and always read 0 in `buttons`.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `gp1`..`gp4`, in, 16 each: raw pad words; bit n is button n.
- `gp_data_ready`, in, 1: level signal; its rising edge marks a new stable frame.
- `ev_valid`, out, 1: FIFO non-empty.
- `ev_ready`, in, 1: consumer accepts the head entry.
- `ev_data`, out, 7: `{pressed, pad[1:0], button[3:0]}`. `pad` is 0..3 for `gp1`..`gp4`. Meaningful only while `ev_valid` is 1.
- `ev_count`, out, `$clog2(FIFO_DEPTH)+1`: number of occupied entries.
- `buttons`, out, 64: normalized pressed state of the last fully scanned frame, `{gp4,gp3,gp2,gp1}` order, 1 = pressed, masked.
- `overflow`, out, 1: sticky; set when an event is dropped because the FIFO is full.
- `missed`, out, 1: sticky; set when a frame edge arrives during SCAN.
- `clr_status`, in, 1: clears `overflow` and `missed`.

## Operation

- **Edge detect:** register `gp_data_ready` into `rdy_q`. A new frame is `gp_data_ready & ~rdy_q`.
- **Normalize:** `cur[i] = (ACTIVE_LOW ? ~raw[i] : raw[i]) & mask`.
- **State IDLE:**
  - On a new frame, latch the normalized 64-bit word into `snap`, set `idx` to 0, and go to SCAN.
- **State SCAN:** each cycle, examine bit `idx`, where `idx` = `pad*16 + button`.
  - If `snap[idx] != prev[idx]`, push `{snap[idx], idx[5:4], idx[3:0]}`.
  - Increment `idx`.
  - When `idx == 63`: `prev <= snap`, `buttons <= snap`, go to IDLE.
- **Frames during SCAN:** a new-frame edge is ignored and sets `missed`.
- **Event order:** pad 0 button 0 first, pad 3 button 15 last.
- **FIFO:**
  - Pop when `ev_valid & ev_ready`.
  - Fullness is evaluated before the current cycle's pop. A push when full is dropped and sets `overflow`, even if a pop occurs the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves `ev_count` unchanged.
- **Status:** if `clr_status` and a set condition coincide, the flag ends up set (set wins).
- **Reset values:**
  - `ev_valid` 0, `ev_count` 0, `buttons` 0, `overflow` 0, `missed` 0.
  - `prev` 0, `rdy_q` 0, state IDLE, `idx` 0.
  - Consequence: the first frame emits a press event for every held button.
- **Reset mid-SCAN:** aborts the scan, flushes the FIFO, and discards the partial snapshot. No events from the aborted frame ever appear.

## Timing

- Edge seen at posedge E (`gp_data_ready`=1, `rdy_q`=0): `snap` is loaded at E.
- Bit i is examined at posedge E+1+i. Its event is written at that edge and is visible on `ev_valid`/`ev_data` immediately after, if the FIFO was empty.
- `buttons` and `prev` are updated at posedge E+64. State is IDLE after E+64, so the earliest next accepted edge is posedge E+65.
- Pop at posedge P: the next entry is presented after P; `ev_count` is decremented after P.
- Throughput: at most 1 push and 1 pop per cycle.
- Frame rate from the upstream reader is far below one per 65 cycles; `missed` indicates a misconfiguration only.

## Test plan

- **Reset, first frame:** after reset, `gp1`=16'hFFFE, others 16'hFFFF, `ACTIVE_LOW`=1, pulse `gp_data_ready` → exactly one event 7'b1_00_0000. `buttons[0]`=1 at E+64; `ev_count`=1.
- **Release across pads:** next frame with `gp1`=16'hFFFF and `gp3`=16'hFFDF → events in order 7'b0_00_0000, then 7'b1_10_0101. `buttons` = 64'h0000_0020_0000_0000.
- **Mask:** `gp2`=16'h7FFF (button 15 pressed, masked by default) → no event; `buttons[31]`=0.
- **Overflow:** `FIFO_DEPTH`=4, `ev_ready`=0, frame with 6 buttons newly pressed → `ev_count`=4, `overflow`=1, and the first 4 events are retained in order. `clr_status` → `overflow`=0.
- **Missed frame and backpressure:** second `gp_data_ready` edge at E+10 → `missed`=1 and only one frame's events are produced. `ev_ready` toggled 1/0 each cycle → no event is lost or duplicated.
- **Reset mid-scan:** assert `rst` at E+20 → `ev_valid`=0 and `ev_count`=0 next cycle. A subsequent frame re-emits presses relative to an all-zero `prev`.
